pulse_burst_gen: RTL

Programmable pulse-burst generator for the morphing-wing peripheral actuator path. On a start request it latches a burst configuration (high width, low width, pulse count) and drives a registered 1-bit pulse train on `out`. `out` feeds the downstream fixed-latency 1-bit delay-line stage directly. Status outputs (`busy`, `done`, `aborted`, `pulse_cnt`) go to the peripheral controller.

---
 rtl/pulse_burst_pkg.sv | 18 +
 rtl/phase_counter.sv | 27 ++
 rtl/pulse_burst_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pulse_burst_pkg.sv
// Shared types and helpers for the pulse-burst generator.
package pulse_burst_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // A zero low phase would merge adjacent pulses, so it is stretched to one cycle.
  function automatic logic [31:0] clamp_low(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times the high and low phases; holds at zero.
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Burst generator: latches a config on start and emits N registered pulses of
// programmable high/low width, with done/aborted strobes for the controller.
//
// state  | meaning
// S_IDLE | waiting for start; out low
// S_HIGH | driving a pulse high for the latched high width
// S_LOW  | gap between pulses, at least one cycle
module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [NUM_W-1:0] pulse_cnt
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] high_q, low_q;
  logic [NUM_W-1:0] num_q;
  logic             start_ok, degenerate, last_pulse, phase_zero;
  logic             cnt_load, cfg_latch;
  logic [CNT_W-1:0] cnt_load_val;
  logic             out_d, busy_d, done_d, aborted_d;
  logic [NUM_W-1:0] pulse_cnt_d;

  assign start_ok   = start && !abort;
  assign degenerate = (high_cycles == '0) || (num_pulses == '0);
  assign last_pulse = (pulse_cnt == num_q);

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (state != S_IDLE),
    .load_val (cnt_load_val),
    .zero     (phase_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok && !degenerate) state_nxt = S_HIGH;
      S_HIGH: begin
        if (abort)           state_nxt = S_IDLE;
        else if (phase_zero) state_nxt = last_pulse ? S_IDLE : S_LOW;
      end
      S_LOW: begin
        if (abort)           state_nxt = S_IDLE;
        else if (phase_zero) state_nxt = S_HIGH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; out/busy follow the next state so
  // they change on the same edge as the state itself.
  always_comb begin
    out_d        = (state_nxt == S_HIGH);
    busy_d       = (state_nxt != S_IDLE);
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    pulse_cnt_d  = pulse_cnt;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cfg_latch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          cfg_latch = 1'b1;
          if (degenerate) begin
            done_d      = 1'b1;
            pulse_cnt_d = '0;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = high_cycles - CNT_W'(1);
            pulse_cnt_d  = NUM_W'(1);
          end
        end
      end
      S_HIGH: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else if (phase_zero) begin
          if (last_pulse) begin
            done_d = 1'b1;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(clamp_low(32'(low_q))) - CNT_W'(1);
          end
        end
      end
      S_LOW: begin
        if (abort) begin
          aborted_d = 1'b1;
        end else if (phase_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = high_q - CNT_W'(1);
          pulse_cnt_d  = pulse_cnt + NUM_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pulse_cnt <= '0;
      high_q    <= '0;
      low_q     <= '0;
      num_q     <= '0;
    end else begin
      out       <= out_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      pulse_cnt <= pulse_cnt_d;
      if (cfg_latch) begin
        high_q <= high_cycles;
        low_q  <= low_cycles;
        num_q  <= num_pulses;
      end
    end
  end

endmodule
